calculation_unit_fraction_adder_pipe: RTL and testbench
=======================================================

// Module: calculation_unit_fraction_adder_pipe
// PURPOSE
//  Pipelined, parametrised fraction adder/subtractor for the calculation unit. Adds or subtracts the
//  short aligned fraction A (1 int bit) and the wide aligned fraction B (2 int bits) and returns an
//  unsigned magnitude, corrected sign and zero flag. Carry chain split over up to 3 register stages.
//  Valid/ready handshake with full backpressure; sits between the aligner and the normaliser.
// PARAMETERS
//  A_WIDTH    24  width of aligned_fraction_a, format [x.xxx], A_WIDTH-1 fraction bits
//  B_WIDTH    49  width of aligned_fraction_b / result, format [xx.xxx]; B_WIDTH >= A_WIDTH+1
//  STAGES     2   pipeline depth / latency in cycles, legal 1..3 (elaboration $error otherwise)
//  TAG_WIDTH  4   opaque sideband carried alongside each operation
// PORTS
//  clk                 in   1          clock, all state on rising edge
//  reset_n             in   1          asynchronous reset, active low
//  in_valid            in   1          operand set valid
//  in_ready            out  1          block can accept an operand set this cycle
//  aligned_fraction_a  in   A_WIDTH    operand A
//  aligned_fraction_b  in   B_WIDTH    operand B
//  subtract            in   1          1 = effective subtraction A-B, 0 = A+B
//  sign_in             in   1          sign of operand A (result sign before correction)
//  tag_in              in   TAG_WIDTH  sideband
//  out_valid           out  1          result valid
//  out_ready           in   1          consumer accepts result
//  fraction_sum        out  B_WIDTH    result magnitude, [xx.xxx] format
//  sign_out            out  1          result sign
//  zero                out  1          fraction_sum == 0
//  tag_out             out  TAG_WIDTH  sideband of the result
// BEHAVIOUR
//  - A_ext = {1'b0, a, (B_WIDTH-1-A_WIDTH)'b0}; add: fraction_sum = A_ext + B (mod 2^B_WIDTH),
//    sign_out = sign_in.
//  - sub: D = A_ext - B in B_WIDTH+1 bits; borrow -> fraction_sum = B - A_ext, sign_out = ~sign_in;
//    else fraction_sum = D, sign_out = sign_in.
//  - Exact cancellation (sub, A_ext == B): fraction_sum = 0, zero = 1, sign_out = 0 (positive zero).
//  - LOW = B_WIDTH/2 (floor). STAGES=1: full compute, registered. STAGES=2: S1 low LOW bits +
//    carry/borrow out; S2 high bits + conditional negate. STAGES=3: S1 low, S2 high, S3 negate + zero.
//  - Latency exactly STAGES cycles from accept (in_valid&in_ready) to out_valid without backpressure.
//  - Each stage owns a valid bit; stage k loads when empty or when stage k+1 is loading/consumed.
//    Last stage advances on out_ready. in_ready = !v[0] | advance[0] (combinational through chain).
//  - Full throughput: one op per cycle with out_ready held high; no bubbles inserted.
//  - out_ready low: out_valid and all outputs held stable until accepted; pipeline fills to STAGES
//    entries, then in_ready = 0.
//  - Data registers load only on stage advance (no reset needed for data); valid bits reset to 0.
//  - Reset (async assert, any time incl. mid-operation): all valids 0, out_valid = 0, in_ready = 1
//    after deassert, fraction_sum/sign_out/zero/tag_out = 0. In-flight ops are dropped.
//  - Order preserved; tag travels with its operation unmodified.
// STRUCTURE
//  - Shared package calculation_unit_pkg: typedef for add/sub stage payload struct (partial sum,
//    carry, subtract, sign, tag), localparam LOW split rule, STAGES legality check function.
//  - One sub-module: calculation_unit_pipe_stage_ctrl (valid bit + advance logic, one per stage);
//    the arithmetic itself stays in this module.
// TESTING (A_WIDTH=24, B_WIDTH=49, STAGES=2 unless noted)
//  1 add a=24'h800000, b=49'h0, sign_in=0 -> after 2 cycles fraction_sum=49'h0_8000_0000_0000,
//    sign_out=0, zero=0.
//  2 sub a=24'h800000 (1.0), b=49'h1_0000_0000_0000 (2.0), sign_in=0 -> fraction_sum=49'h0_8000_0000_0000,
//    sign_out=1.
//  3 sub a=24'h000001, b=49'h0_0000_0000_0001 -> borrow across split: fraction_sum=49'h0_0000_00FF_FFFF,
//    sign_out=sign_in.
//  4 sub a=24'hC00000, b=49'h0_C000_0000_0000, sign_in=1 -> fraction_sum=0, zero=1, sign_out=0.
//  5 10 back-to-back ops, out_ready low for cycles 3-6 -> in_ready drops after 2 held, outputs stable,
//    all 10 results in order with tags 0..9; STAGES=1 and 3 repeated, latency 1 and 3.
//  6 reset_n pulsed low with 2 ops in flight -> out_valid=0 immediately, no stale result emitted after
//    release, next op completes normally.

Source files
------------

// File: rtl/calculation_unit_pkg.sv
// Shared types, split rule and parameter checks for the calculation unit fraction adder.
package calculation_unit_pkg;

  localparam int MIN_STAGES = 1;
  localparam int MAX_STAGES = 3;

  // Per-stage control payload that travels with a partial result.
  // carry holds the low-half carry/borrow after the low stage and the
  // "needs negation" flag after the high stage. The partial sum and tag
  // widths depend on module parameters, so those vectors sit beside this
  // struct inside the adder instead of inside it.
  typedef struct packed {
    logic carry;
    logic subtract;
    logic sign;
  } stage_flags_t;

  // The low half of the carry chain is the lower floor(B_WIDTH/2) bits.
  function automatic int low_split(input int b_width);
    return b_width / 2;
  endfunction

  // The pipeline supports a depth of one to three register stages.
  function automatic bit stages_legal(input int stages);
    return (stages >= MIN_STAGES) && (stages <= MAX_STAGES);
  endfunction

endpackage

// File: rtl/calculation_unit_pipe_stage_ctrl.sv
// Valid bit and load control for one pipeline stage with full backpressure.
module calculation_unit_pipe_stage_ctrl (
  input  logic clk,
  input  logic reset_n,
  input  logic up_valid,
  input  logic down_ready,
  output logic load,
  output logic valid
);

  logic valid_d;
  logic valid_q;
  logic stage_ready;

  // The stage can take new data when it is empty or its content is leaving this cycle.
  always_comb begin
    stage_ready = !valid_q || down_ready;
    load        = up_valid && stage_ready;
    valid_d     = load || (valid_q && !down_ready);
  end

  // Valid bit is the only control state; dropping it on reset discards in-flight data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;

endmodule

// File: rtl/calculation_unit_fraction_adder_pipe.sv
// Pipelined fraction adder/subtractor: A_ext +/- B with magnitude/sign correction and zero flag.
module calculation_unit_fraction_adder_pipe
  import calculation_unit_pkg::*;
#(
  parameter int A_WIDTH   = 24,
  parameter int B_WIDTH   = 49,
  parameter int STAGES    = 2,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   aligned_fraction_a,
  input  logic [B_WIDTH-1:0]   aligned_fraction_b,
  input  logic                 subtract,
  input  logic                 sign_in,
  input  logic [TAG_WIDTH-1:0] tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [B_WIDTH-1:0]   fraction_sum,
  output logic                 sign_out,
  output logic                 zero,
  output logic [TAG_WIDTH-1:0] tag_out
);

  localparam int LOW  = low_split(B_WIDTH);
  localparam int HIGH = B_WIDTH - LOW;
  localparam int HIGH_W = HIGH + 1;
  localparam int PAD  = B_WIDTH - 1 - A_WIDTH;

  if (!stages_legal(STAGES)) begin : g_bad_stages
    $error("calculation_unit_fraction_adder_pipe: STAGES=%0d outside 1..3", STAGES);
  end
  if (B_WIDTH < A_WIDTH + 1) begin : g_bad_widths
    $error("calculation_unit_fraction_adder_pipe: B_WIDTH=%0d must be >= A_WIDTH+1", B_WIDTH);
  end

  // Low half add/sub; the extra top bit is the carry (add) or borrow (sub) into the high half.
  function automatic logic [LOW:0] lo_add(input logic [LOW-1:0] a, input logic [LOW-1:0] b,
                                          input logic sub);
    if (sub) begin
      return {1'b0, a} - {1'b0, b};
    end
    return {1'b0, a} + {1'b0, b};
  endfunction

  // High half add/sub with incoming carry/borrow; for sub the top bit is the final borrow.
  function automatic logic [HIGH:0] hi_add(input logic [HIGH-1:0] a, input logic [HIGH-1:0] b,
                                           input logic sub, input logic c);
    if (sub) begin
      return {1'b0, a} - {1'b0, b} - HIGH_W'(c);
    end
    return {1'b0, a} + {1'b0, b} + HIGH_W'(c);
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake chain
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] stg_valid;
  logic [STAGES-1:0] stg_load;
  logic [STAGES-1:0] stg_up_valid;
  logic [STAGES-1:0] stg_down_ready;

  // Ready ripples back from the consumer through every stage; built from valid bits only.
  always_comb begin
    logic ready_chain;
    ready_chain    = out_ready;
    stg_down_ready = '0;
    stg_up_valid   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      stg_down_ready[k] = ready_chain;
      ready_chain       = !stg_valid[k] || ready_chain;
      stg_up_valid[k]   = (k == 0) ? in_valid : stg_valid[(k == 0) ? 0 : k - 1];
    end
    in_ready = ready_chain;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage_ctrl
    calculation_unit_pipe_stage_ctrl u_ctrl (
      .clk        (clk),
      .reset_n    (reset_n),
      .up_valid   (stg_up_valid[k]),
      .down_ready (stg_down_ready[k]),
      .load       (stg_load[k]),
      .valid      (stg_valid[k])
    );
  end

  // ---------------------------------------------------------------------------
  // Front end: align A into the [xx.xxx] frame and compute the low half
  // ---------------------------------------------------------------------------
  logic [B_WIDTH-1:0] a_ext;
  logic [LOW:0]       front_lo;

  // A gets one leading zero integer bit and zero padding below its fraction.
  always_comb begin
    a_ext    = B_WIDTH'(aligned_fraction_a) << PAD;
    front_lo = lo_add(a_ext[LOW-1:0], aligned_fraction_b[LOW-1:0], subtract);
  end

  // ---------------------------------------------------------------------------
  // High half: sources depend on whether the low half was registered
  // ---------------------------------------------------------------------------
  logic [LOW-1:0]       hi_src_lo;
  logic                 hi_src_c;
  logic [HIGH-1:0]      hi_src_a;
  logic [HIGH-1:0]      hi_src_b;
  logic                 hi_src_sub;
  logic                 hi_src_sign;
  logic [TAG_WIDTH-1:0] hi_src_tag;
  logic [HIGH:0]        hi_part;
  logic [B_WIDTH-1:0]   hi_raw;
  logic                 hi_neg;

  if (STAGES == 1) begin : g_no_low_stage
    assign hi_src_lo   = front_lo[LOW-1:0];
    assign hi_src_c    = front_lo[LOW];
    assign hi_src_a    = a_ext[B_WIDTH-1:LOW];
    assign hi_src_b    = aligned_fraction_b[B_WIDTH-1:LOW];
    assign hi_src_sub  = subtract;
    assign hi_src_sign = sign_in;
    assign hi_src_tag  = tag_in;
  end else begin : g_low_stage
    logic [LOW-1:0]       lo_sum_d, lo_sum_q;
    logic [HIGH-1:0]      lo_a_d, lo_a_q;
    logic [HIGH-1:0]      lo_b_d, lo_b_q;
    stage_flags_t         lo_flags_d, lo_flags_q;
    logic [TAG_WIDTH-1:0] lo_tag_d, lo_tag_q;

    // First stage captures the low half result and the untouched high operand halves.
    always_comb begin
      lo_sum_d   = lo_sum_q;
      lo_a_d     = lo_a_q;
      lo_b_d     = lo_b_q;
      lo_flags_d = lo_flags_q;
      lo_tag_d   = lo_tag_q;
      if (stg_load[0]) begin
        lo_sum_d            = front_lo[LOW-1:0];
        lo_a_d              = a_ext[B_WIDTH-1:LOW];
        lo_b_d              = aligned_fraction_b[B_WIDTH-1:LOW];
        lo_flags_d.carry    = front_lo[LOW];
        lo_flags_d.subtract = subtract;
        lo_flags_d.sign     = sign_in;
        lo_tag_d            = tag_in;
      end
    end

    // Data registers need no reset; the stage valid bit qualifies them.
    always_ff @(posedge clk) begin
      lo_sum_q   <= lo_sum_d;
      lo_a_q     <= lo_a_d;
      lo_b_q     <= lo_b_d;
      lo_flags_q <= lo_flags_d;
      lo_tag_q   <= lo_tag_d;
    end

    assign hi_src_lo   = lo_sum_q;
    assign hi_src_c    = lo_flags_q.carry;
    assign hi_src_a    = lo_a_q;
    assign hi_src_b    = lo_b_q;
    assign hi_src_sub  = lo_flags_q.subtract;
    assign hi_src_sign = lo_flags_q.sign;
    assign hi_src_tag  = lo_tag_q;
  end

  // High half finishes the raw difference; a final borrow means B was larger than A_ext.
  always_comb begin
    hi_part = hi_add(hi_src_a, hi_src_b, hi_src_sub, hi_src_c);
    hi_raw  = {hi_part[HIGH-1:0], hi_src_lo};
    hi_neg  = hi_src_sub && hi_part[HIGH];
  end

  // ---------------------------------------------------------------------------
  // Correction: conditional negate, sign fix and zero detect
  // ---------------------------------------------------------------------------
  logic [B_WIDTH-1:0]   fin_raw;
  logic                 fin_neg;
  logic                 fin_sub;
  logic                 fin_sign;
  logic [TAG_WIDTH-1:0] fin_tag;

  if (STAGES == 3) begin : g_mid_stage
    logic [B_WIDTH-1:0]   mid_raw_d, mid_raw_q;
    stage_flags_t         mid_flags_d, mid_flags_q;
    logic [TAG_WIDTH-1:0] mid_tag_d, mid_tag_q;

    // Middle stage holds the raw two's complement difference and whether it must be negated.
    always_comb begin
      mid_raw_d   = mid_raw_q;
      mid_flags_d = mid_flags_q;
      mid_tag_d   = mid_tag_q;
      if (stg_load[1]) begin
        mid_raw_d            = hi_raw;
        mid_flags_d.carry    = hi_neg;
        mid_flags_d.subtract = hi_src_sub;
        mid_flags_d.sign     = hi_src_sign;
        mid_tag_d            = hi_src_tag;
      end
    end

    // Data registers need no reset; the stage valid bit qualifies them.
    always_ff @(posedge clk) begin
      mid_raw_q   <= mid_raw_d;
      mid_flags_q <= mid_flags_d;
      mid_tag_q   <= mid_tag_d;
    end

    assign fin_raw  = mid_raw_q;
    assign fin_neg  = mid_flags_q.carry;
    assign fin_sub  = mid_flags_q.subtract;
    assign fin_sign = mid_flags_q.sign;
    assign fin_tag  = mid_tag_q;
  end else begin : g_no_mid_stage
    assign fin_raw  = hi_raw;
    assign fin_neg  = hi_neg;
    assign fin_sub  = hi_src_sub;
    assign fin_sign = hi_src_sign;
    assign fin_tag  = hi_src_tag;
  end

  logic [B_WIDTH-1:0] res_mag;
  logic               res_zero;
  logic               res_sign;

  // Negating A_ext-B gives B-A_ext; exact cancellation on subtract yields positive zero.
  always_comb begin
    res_mag  = fin_neg ? -fin_raw : fin_raw;
    res_zero = (res_mag == '0);
    res_sign = fin_neg ? !fin_sign : fin_sign;
    if (res_zero && fin_sub) begin
      res_sign = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  logic [B_WIDTH-1:0]   res_sum_d, res_sum_q;
  logic                 res_sign_d, res_sign_q;
  logic                 res_zero_d, res_zero_q;
  logic [TAG_WIDTH-1:0] res_tag_d, res_tag_q;

  // Last stage captures the finished result and holds it until the consumer takes it.
  always_comb begin
    res_sum_d  = res_sum_q;
    res_sign_d = res_sign_q;
    res_zero_d = res_zero_q;
    res_tag_d  = res_tag_q;
    if (stg_load[STAGES-1]) begin
      res_sum_d  = res_mag;
      res_sign_d = res_sign;
      res_zero_d = res_zero;
      res_tag_d  = fin_tag;
    end
  end

  // Data registers need no reset; outputs are forced to zero while nothing is valid.
  always_ff @(posedge clk) begin
    res_sum_q  <= res_sum_d;
    res_sign_q <= res_sign_d;
    res_zero_q <= res_zero_d;
    res_tag_q  <= res_tag_d;
  end

  assign out_valid    = stg_valid[STAGES-1];
  assign fraction_sum = out_valid ? res_sum_q  : '0;
  assign sign_out     = out_valid ? res_sign_q : 1'b0;
  assign zero         = out_valid ? res_zero_q : 1'b0;
  assign tag_out      = out_valid ? res_tag_q  : '0;

endmodule

// File: tb/tb_calculation_unit_fraction_adder_pipe.sv
// Directed self-checking bench for the fraction adder at pipeline depths 1, 2 and 3.
module tb_calculation_unit_fraction_adder_pipe;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic [3:1]        in_valid = '0;
  logic [3:1]        out_ready = '0;
  logic [3:1]        in_ready;
  logic [3:1]        out_valid;
  logic [3:1]        sign_out;
  logic [3:1]        zero;
  logic [3:1][48:0]  fsum;
  logic [3:1][3:0]   tag_out;

  logic [23:0] a = '0;
  logic [48:0] b = '0;
  logic        sub = 1'b0;
  logic        sign_in = 1'b0;
  logic [3:0]  tag_in = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  calculation_unit_fraction_adder_pipe #(.A_WIDTH(24), .B_WIDTH(49), .STAGES(1), .TAG_WIDTH(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .aligned_fraction_a(a), .aligned_fraction_b(b), .subtract(sub), .sign_in(sign_in),
    .tag_in(tag_in), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .fraction_sum(fsum[1]), .sign_out(sign_out[1]), .zero(zero[1]), .tag_out(tag_out[1])
  );

  calculation_unit_fraction_adder_pipe #(.A_WIDTH(24), .B_WIDTH(49), .STAGES(2), .TAG_WIDTH(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .aligned_fraction_a(a), .aligned_fraction_b(b), .subtract(sub), .sign_in(sign_in),
    .tag_in(tag_in), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .fraction_sum(fsum[2]), .sign_out(sign_out[2]), .zero(zero[2]), .tag_out(tag_out[2])
  );

  calculation_unit_fraction_adder_pipe #(.A_WIDTH(24), .B_WIDTH(49), .STAGES(3), .TAG_WIDTH(4)) dut3 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .aligned_fraction_a(a), .aligned_fraction_b(b), .subtract(sub), .sign_in(sign_in),
    .tag_in(tag_in), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .fraction_sum(fsum[3]), .sign_out(sign_out[3]), .zero(zero[3]), .tag_out(tag_out[3])
  );

  // One comparison: counts it and reports observed/expected on mismatch.
  task automatic check_output(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Single operation through pipeline s: latency, result fields and release afterwards.
  task automatic apply_stimulus(input int s, input string name, input logic [23:0] av,
                                input logic [48:0] bv, input logic subv, input logic signv,
                                input logic [3:0] tagv, input logic [48:0] exp_sum,
                                input logic exp_sign, input logic exp_zero);
    int lat;
    @(negedge clk);
    a = av; b = bv; sub = subv; sign_in = signv; tag_in = tagv;
    in_valid[s] = 1'b1;
    out_ready[s] = 1'b1;
    #1 check_output({name, " in_ready"}, 64'(in_ready[s]), 64'd1);
    @(negedge clk);
    in_valid[s] = 1'b0;
    lat = 1;
    while (!out_valid[s] && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check_output({name, " latency"}, 64'(lat), 64'(s));
    check_output({name, " sum"}, 64'(fsum[s]), 64'(exp_sum));
    check_output({name, " sign"}, 64'(sign_out[s]), 64'(exp_sign));
    check_output({name, " zero"}, 64'(zero[s]), 64'(exp_zero));
    check_output({name, " tag"}, 64'(tag_out[s]), 64'(tagv));
    @(negedge clk);
    check_output({name, " drained"}, 64'(out_valid[s]), 64'd0);
  endtask

  // Ten back-to-back adds with the consumer stalled on cycles 3..6.
  task automatic stream_test(input int s);
    int sent;
    int got;
    int first_cycle;
    logic [23:0] sa;
    logic [48:0] sb;
    logic [48:0] exp_sum;
    sent = 0;
    got = 0;
    first_cycle = -1;
    for (int c = 0; c < 40 && got < 10; c++) begin
      @(negedge clk);
      out_ready[s] = !(c >= 3 && c <= 6);
      if (out_valid[s]) begin
        if (first_cycle < 0) begin
          first_cycle = c;
          check_output($sformatf("stream%0d latency", s), 64'(first_cycle), 64'(s));
        end
        sa = 24'(got * 24'h01A2B3);
        sb = 49'(got) * 49'h0_1111_1111_1111;
        exp_sum = (49'(sa) << 24) + sb;
        check_output($sformatf("stream%0d sum[%0d]", s, got), 64'(fsum[s]), 64'(exp_sum));
        check_output($sformatf("stream%0d tag[%0d]", s, got), 64'(tag_out[s]), 64'(got));
        if (out_ready[s]) got++;
      end
      if (sent < 10) begin
        a = 24'(sent * 24'h01A2B3);
        b = 49'(sent) * 49'h0_1111_1111_1111;
        sub = 1'b0;
        sign_in = 1'b0;
        tag_in = 4'(sent);
        in_valid[s] = 1'b1;
      end else begin
        in_valid[s] = 1'b0;
      end
      #1;
      if (sent < 10) begin
        if (c >= 4 && c <= 6) begin
          check_output($sformatf("stream%0d in_ready stalled c%0d", s, c), 64'(in_ready[s]), 64'd0);
        end else if (c <= 2) begin
          check_output($sformatf("stream%0d in_ready flowing c%0d", s, c), 64'(in_ready[s]), 64'd1);
        end
        if (in_ready[s]) sent++;
      end
    end
    in_valid[s] = 1'b0;
    out_ready[s] = 1'b1;
    check_output($sformatf("stream%0d count", s), 64'(got), 64'd10);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state while reset_n is low
    repeat (3) @(negedge clk);
    for (int s = 1; s <= 3; s++) begin
      check_output($sformatf("reset%0d out_valid", s), 64'(out_valid[s]), 64'd0);
      check_output($sformatf("reset%0d sum", s), 64'(fsum[s]), 64'd0);
      check_output($sformatf("reset%0d sign", s), 64'(sign_out[s]), 64'd0);
      check_output($sformatf("reset%0d zero", s), 64'(zero[s]), 64'd0);
      check_output($sformatf("reset%0d tag", s), 64'(tag_out[s]), 64'd0);
    end
    reset_n = 1'b1;
    #1;
    for (int s = 1; s <= 3; s++) begin
      check_output($sformatf("reset%0d in_ready", s), 64'(in_ready[s]), 64'd1);
    end

    // Directed arithmetic on the default depth
    apply_stimulus(2, "add 1.0+0", 24'h800000, 49'h0, 1'b0, 1'b0, 4'h1,
                   49'h0_8000_0000_0000, 1'b0, 1'b0);
    apply_stimulus(2, "sub 1.0-2.0", 24'h800000, 49'h1_0000_0000_0000, 1'b1, 1'b0, 4'h2,
                   49'h0_8000_0000_0000, 1'b1, 1'b0);
    apply_stimulus(2, "sub split borrow", 24'h000001, 49'h0_0000_0000_0001, 1'b1, 1'b1, 4'h3,
                   49'h0_0000_00FF_FFFF, 1'b1, 1'b0);
    apply_stimulus(2, "sub cancel", 24'hC00000, 49'h0_C000_0000_0000, 1'b1, 1'b1, 4'h4,
                   49'h0, 1'b0, 1'b1);
    apply_stimulus(2, "add wrap", 24'hFFFFFF, 49'h1_FFFF_FFFF_FFFF, 1'b0, 1'b1, 4'h5,
                   49'h0_FFFF_FEFF_FFFF, 1'b1, 1'b0);
    apply_stimulus(2, "sub positive", 24'h800000, 49'h0_0000_0000_0003, 1'b1, 1'b1, 4'h6,
                   49'h0_7FFF_FFFF_FFFD, 1'b1, 1'b0);
    apply_stimulus(2, "sub negate low", 24'h400000, 49'h0_4000_0000_0001, 1'b1, 1'b0, 4'h7,
                   49'h0_0000_0000_0001, 1'b1, 1'b0);

    // Same corner cases at the other depths
    apply_stimulus(1, "s1 sub 1.0-2.0", 24'h800000, 49'h1_0000_0000_0000, 1'b1, 1'b0, 4'h8,
                   49'h0_8000_0000_0000, 1'b1, 1'b0);
    apply_stimulus(1, "s1 sub split borrow", 24'h000001, 49'h0_0000_0000_0001, 1'b1, 1'b1, 4'h9,
                   49'h0_0000_00FF_FFFF, 1'b1, 1'b0);
    apply_stimulus(3, "s3 sub split borrow", 24'h000001, 49'h0_0000_0000_0001, 1'b1, 1'b0, 4'hA,
                   49'h0_0000_00FF_FFFF, 1'b0, 1'b0);
    apply_stimulus(3, "s3 sub cancel", 24'hC00000, 49'h0_C000_0000_0000, 1'b1, 1'b1, 4'hB,
                   49'h0, 1'b0, 1'b1);
    apply_stimulus(3, "s3 sub negate low", 24'h400000, 49'h0_4000_0000_0001, 1'b1, 1'b1, 4'hC,
                   49'h0_0000_0000_0001, 1'b0, 1'b0);

    // Streaming with backpressure at each depth
    stream_test(1);
    stream_test(2);
    stream_test(3);

    // Reset with two operations in flight
    @(negedge clk);
    a = 24'h800000; b = 49'h0; sub = 1'b0; sign_in = 1'b0; tag_in = 4'hD;
    in_valid[2] = 1'b1;
    out_ready[2] = 1'b1;
    @(negedge clk);
    tag_in = 4'hE;
    @(negedge clk);
    in_valid[2] = 1'b0;
    check_output("midreset busy before", 64'(out_valid[2]), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check_output("midreset out_valid", 64'(out_valid[2]), 64'd0);
    check_output("midreset sum", 64'(fsum[2]), 64'd0);
    check_output("midreset tag", 64'(tag_out[2]), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_output("midreset in_ready", 64'(in_ready[2]), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output($sformatf("midreset stale c%0d", i), 64'(out_valid[2]), 64'd0);
    end
    apply_stimulus(2, "after reset", 24'h800000, 49'h1_0000_0000_0000, 1'b1, 1'b1, 4'hF,
                   49'h0_8000_0000_0000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
